// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants and hex-to-segment decode
// for the multiplexed seven-segment scan controller.
package seg7_pkg;

   localparam logic [6:0] SEG_OFF = 7'h7F;

   // {g,f,e,d,c,b,a}, active-low, indexed by hex value
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,
      7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03,
      7'h46, 7'h21, 7'h06, 7'h0E
   };

   function automatic logic [6:0] seg7_decode(input logic [3:0] v);
      return SEG_TABLE[v];
   endfunction

endpackage

// File: rtl/seg7_prescaler.sv
// seg7_prescaler: slot timer counting 0..DIV-1.
// tick marks the wrap edge; in_dead flags that the slot cycle being entered lies in the dead window.
module seg7_prescaler #(
   parameter int DIV  = 100000,
   parameter int DEAD = 4
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick,
   output logic in_dead
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // next count, wrap detect and dead-window lookahead
   always_comb begin
      tick    = (count_q == CW'(DIV - 1));
      count_d = tick ? '0 : count_q + CW'(1);
      in_dead = int'(count_d) < DEAD;
   end

   // counter register
   always_ff @(posedge clk) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: time-multiplexed common-anode 7-seg driver with dead time.
// Optional build macro SEG7_LEADING_ZERO_BLANK_EN enables leading-zero suppression.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter  int DIGITS = 8,
   parameter  int DIV    = 100000,
   parameter  int DEAD   = 4,
   localparam int AW     = $clog2(DIGITS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [3:0]        wr_data,
   input  logic              wr_dp,
   input  logic [DIGITS-1:0] blank,
   output logic [6:0]        seg,
   output logic              dp,
   output logic [DIGITS-1:0] an,
   output logic [AW-1:0]     cur_digit
);

   logic              tick;
   logic              in_dead;
   logic [AW-1:0]     cur_q, cur_d;
   logic [3:0]        val_q [DIGITS];
   logic [3:0]        val_d [DIGITS];
   logic [DIGITS-1:0] dpv_q, dpv_d;
   logic [DIGITS-1:0] lz_hide;
   logic [6:0]        seg_q, seg_d;
   logic              dp_out_q, dp_out_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic              dark;

   seg7_prescaler #(
      .DIV  (DIV),
      .DEAD (DEAD)
   ) u_presc (
      .clk     (clk),
      .rst_n   (rst_n),
      .tick    (tick),
      .in_dead (in_dead)
   );

   // digit pointer advances on the slot wrap
   always_comb begin
      cur_d = cur_q;
      if (tick) begin
         cur_d = (cur_q == AW'(DIGITS - 1)) ? '0 : cur_q + AW'(1);
      end
   end

   // write port; out-of-range addresses are dropped
   always_comb begin
      val_d = val_q;
      dpv_d = dpv_q;
      if (wr_en && (int'(wr_addr) < DIGITS)) begin
         val_d[wr_addr] = wr_data;
         dpv_d[wr_addr] = wr_dp;
      end
   end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
   // hide digits that are zero with every higher digit also zero
   always_comb begin
      logic all_zero;
      lz_hide  = '0;
      all_zero = 1'b1;
      for (int i = DIGITS - 1; i > 0; i--) begin
         all_zero   = all_zero && (val_q[i] == 4'd0) && !dpv_q[i];
         lz_hide[i] = all_zero;
      end
   end
`else
   assign lz_hide = '0;
`endif

   // display outputs for the slot cycle being entered
   always_comb begin
      dark     = in_dead | blank[cur_d] | lz_hide[cur_d];
      an_d     = ~({{(DIGITS - 1){1'b0}}, 1'b1} << cur_d);
      seg_d    = seg7_decode(val_q[cur_d]);
      dp_out_d = ~dpv_q[cur_d];
      if (dark) begin
         an_d     = '1;
         seg_d    = SEG_OFF;
         dp_out_d = 1'b1;
      end
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_q    <= '0;
         dpv_q    <= '0;
         seg_q    <= SEG_OFF;
         dp_out_q <= 1'b1;
         an_q     <= '1;
         for (int i = 0; i < DIGITS; i++) val_q[i] <= '0;
      end else begin
         cur_q    <= cur_d;
         val_q    <= val_d;
         dpv_q    <= dpv_d;
         seg_q    <= seg_d;
         dp_out_q <= dp_out_d;
         an_q     <= an_d;
      end
   end

   assign seg       = seg_q;
   assign dp        = dp_out_q;
   assign an        = an_q;
   assign cur_digit = cur_q;

endmodule
